// File: rtl/wave_meas_pkg.sv
// Shared types and helpers for the waveform measurement block: FSM encoding,
// saturating arithmetic and the half-scale reset constant.
package wave_meas_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StAcq
    } state_e;

    function automatic int unsigned half_scale(int unsigned data_w);
        return 32'd1 << (data_w - 32'd1);
    endfunction

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b, logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(logic [31:0] a, logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/wave_meas_param_if.sv
// Sample input and measurement result bundle between the front end (master)
// and the measurement block (slave).
interface wave_meas_param_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned CNT_W  = 32
);
    logic              en_i;
    logic              din_vld_i;
    logic [DATA_W-1:0] din_i;
    logic [DATA_W-1:0] min_o;
    logic [DATA_W-1:0] max_o;
    logic [DATA_W-1:0] vpp_o;
    logic [DATA_W-1:0] mid_o;
    logic [CNT_W-1:0]  fre_o;
    logic              meas_vld_o;
    logic              fre_vld_o;
    logic              overrange_o;

    modport master (
        output en_i, din_vld_i, din_i,
        input  min_o, max_o, vpp_o, mid_o, fre_o, meas_vld_o, fre_vld_o, overrange_o
    );

    modport slave (
        input  en_i, din_vld_i, din_i,
        output min_o, max_o, vpp_o, mid_o, fre_o, meas_vld_o, fre_vld_o, overrange_o
    );
endinterface

// File: rtl/schmitt_xing_det.sv
// Hysteresis-qualified rising-crossing detector around a movable midpoint.
// Emits a one-cycle pulse the cycle after the qualifying sample.
module schmitt_xing_det
    import wave_meas_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned HYST   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              din_vld_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [DATA_W-1:0] mid_i,
    output logic              xing_o
);

    localparam logic [31:0] FullScale = 32'((64'd1 << DATA_W) - 64'd1);
    localparam logic [DATA_W-1:0] ThrHiRst =
        DATA_W'(sat_add(half_scale(DATA_W), HYST, FullScale));
    localparam logic [DATA_W-1:0] ThrLoRst = DATA_W'(sat_sub(half_scale(DATA_W), HYST));

    logic [DATA_W-1:0] thr_hi_d, thr_lo_d;
    logic [DATA_W-1:0] thr_hi_q, thr_lo_q;
    logic              armed_q;
    logic              xing_q;

    assign thr_hi_d = DATA_W'(sat_add(32'(mid_i), HYST, FullScale));
    assign thr_lo_d = DATA_W'(sat_sub(32'(mid_i), HYST));

    // Thresholds are registered, so a new midpoint applies one cycle after it is published.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thr_hi_q <= ThrHiRst;
            thr_lo_q <= ThrLoRst;
            armed_q  <= 1'b0;
            xing_q   <= 1'b0;
        end else begin
            thr_hi_q <= thr_hi_d;
            thr_lo_q <= thr_lo_d;
            xing_q   <= 1'b0;
            if (clr_i) begin
                armed_q <= 1'b0;
            end else if (din_vld_i) begin
                if (din_i <= thr_lo_q) begin
                    armed_q <= 1'b1;
                end else if (din_i >= thr_hi_q && armed_q) begin
                    xing_q  <= 1'b1;
                    armed_q <= 1'b0;
                end
            end
        end
    end

    assign xing_o = xing_q;

endmodule

// File: rtl/wave_meas_param.sv
// Windowed min/max/peak-to-peak/midpoint measurement plus gated frequency count
// of hysteresis-qualified rising crossings of the previous window's midpoint.
module wave_meas_param
    import wave_meas_pkg::*;
#(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WIN_LEN  = 1000000,
    parameter int unsigned GATE_LEN = 50000000,
    parameter int unsigned HYST     = 4
) (
    input logic              clk_i,
    input logic              rst_ni,
    wave_meas_param_if.slave bus
);

    localparam int unsigned WinW  = $clog2(WIN_LEN);
    localparam int unsigned GateW = $clog2(GATE_LEN);
    localparam logic [DATA_W-1:0] FullScale = '1;
    localparam logic [DATA_W-1:0] HalfScale = DATA_W'(half_scale(DATA_W));

    state_e            state_q;
    logic [WinW-1:0]   win_cnt_q;
    logic [GateW-1:0]  gate_cnt_q;
    logic [CNT_W-1:0]  xing_cnt_q;
    logic [DATA_W-1:0] run_min_q, run_max_q;
    logic              run_ovr_q;
    logic [DATA_W-1:0] min_q, max_q, vpp_q, mid_q;
    logic [CNT_W-1:0]  fre_q;
    logic              meas_vld_q, fre_vld_q, ovr_q;

    logic              xing;
    logic              clip;
    logic              win_end;
    logic              gate_end;
    logic [DATA_W-1:0] new_min, new_max;
    logic              new_ovr;
    logic [DATA_W:0]   mid_sum;
    logic [CNT_W-1:0]  xing_cnt_sat;

    // First sample of a window seeds both extremes; later samples compare independently.
    always_comb begin
        clip     = (bus.din_i == '0) || (bus.din_i == FullScale);
        new_min  = (state_q == StFirst || bus.din_i < run_min_q) ? bus.din_i : run_min_q;
        new_max  = (state_q == StFirst || bus.din_i > run_max_q) ? bus.din_i : run_max_q;
        new_ovr  = ((state_q == StFirst) ? 1'b0 : run_ovr_q) | clip;
        mid_sum  = {1'b0, new_min} + {1'b0, new_max};
        win_end  = (state_q == StAcq) && (win_cnt_q == WinW'(WIN_LEN - 1));
        gate_end = (gate_cnt_q == GateW'(GATE_LEN - 1));
        xing_cnt_sat = (xing && xing_cnt_q != '1) ? xing_cnt_q + 1'b1 : xing_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            win_cnt_q  <= '0;
            gate_cnt_q <= '0;
            xing_cnt_q <= '0;
            run_min_q  <= '0;
            run_max_q  <= '0;
            run_ovr_q  <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            vpp_q      <= '0;
            mid_q      <= HalfScale;
            fre_q      <= '0;
            meas_vld_q <= 1'b0;
            fre_vld_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            meas_vld_q <= 1'b0;
            fre_vld_q  <= 1'b0;
            if (!bus.en_i) begin
                // Partial window and gate are dropped; published results hold.
                state_q    <= StIdle;
                win_cnt_q  <= '0;
                gate_cnt_q <= '0;
                xing_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StFirst;
                    StFirst, StAcq: begin
                        if (bus.din_vld_i) begin
                            if (win_end) begin
                                min_q      <= new_min;
                                max_q      <= new_max;
                                vpp_q      <= new_max - new_min;
                                mid_q      <= mid_sum[DATA_W:1];
                                ovr_q      <= new_ovr;
                                meas_vld_q <= 1'b1;
                                win_cnt_q  <= '0;
                                state_q    <= StFirst;
                            end else begin
                                run_min_q <= new_min;
                                run_max_q <= new_max;
                                run_ovr_q <= new_ovr;
                                win_cnt_q <= win_cnt_q + 1'b1;
                                state_q   <= StAcq;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase

                if (state_q != StIdle) begin
                    if (gate_end) begin
                        gate_cnt_q <= '0;
                        fre_q      <= xing_cnt_sat;
                        fre_vld_q  <= 1'b1;
                        xing_cnt_q <= '0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + 1'b1;
                        xing_cnt_q <= xing_cnt_sat;
                    end
                end
            end
        end
    end

    schmitt_xing_det #(
        .DATA_W(DATA_W),
        .HYST  (HYST)
    ) u_xing_det (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (!bus.en_i || state_q == StIdle),
        .din_vld_i(bus.din_vld_i),
        .din_i    (bus.din_i),
        .mid_i    (mid_q),
        .xing_o   (xing)
    );

    assign bus.min_o       = min_q;
    assign bus.max_o       = max_q;
    assign bus.vpp_o       = vpp_q;
    assign bus.mid_o       = mid_q;
    assign bus.fre_o       = fre_q;
    assign bus.meas_vld_o  = meas_vld_q;
    assign bus.fre_vld_o   = fre_vld_q;
    assign bus.overrange_o = ovr_q;

endmodule

// File: tb/tb_wave_meas_param.sv
// Directed bench for wave_meas_param with an 8-sample window, 100-clock gate
// and hysteresis of 4 LSBs.
module tb_wave_meas_param;

    typedef logic [7:0][9:0] win_t;
    typedef struct packed {
        win_t       smp;
        logic [9:0] mn;
        logic [9:0] mx;
        logic [9:0] vpp;
        logic [9:0] mid;
        logic       ovr;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t tbl [6];
    bit   early;
    bit   seen;
    int   pulses;
    int   last;

    wave_meas_param_if #(.DATA_W(10), .CNT_W(32)) bus ();

    wave_meas_param #(
        .DATA_W  (10),
        .CNT_W   (32),
        .WIN_LEN (8),
        .GATE_LEN(100),
        .HYST    (4)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic win_t w8(input logic [9:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic start_meas();
        bus.en_i      = 1'b0;
        bus.din_vld_i = 1'b0;
        tick();
        bus.en_i = 1'b1;
        tick();
    endtask

    task automatic send_window(input win_t s, output bit saw_early);
        saw_early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.din_vld_i = 1'b1;
            bus.din_i     = s[i];
            tick();
            if (i < 7 && bus.meas_vld_o) saw_early = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " min"}, 32'(bus.min_o), 0);
        chk({tag, " max"}, 32'(bus.max_o), 0);
        chk({tag, " vpp"}, 32'(bus.vpp_o), 0);
        chk({tag, " mid"}, 32'(bus.mid_o), 512);
        chk({tag, " fre"}, bus.fre_o, 0);
        chk({tag, " meas_vld"}, 32'(bus.meas_vld_o), 0);
        chk({tag, " fre_vld"}, 32'(bus.fre_vld_o), 0);
        chk({tag, " overrange"}, 32'(bus.overrange_o), 0);
    endtask

    initial begin
        tbl[0] = '{w8(100, 101, 102, 103, 104, 105, 106, 107), 10'd100, 10'd107, 10'd7,
                   10'd103, 1'b0};
        tbl[1] = '{w8(500, 400, 300, 200, 600, 100, 350, 450), 10'd100, 10'd600, 10'd500,
                   10'd350, 1'b0};
        tbl[2] = '{w8(300, 1023, 310, 320, 330, 340, 350, 360), 10'd300, 10'd1023, 10'd723,
                   10'd661, 1'b1};
        tbl[3] = '{w8(10, 20, 30, 40, 50, 60, 70, 80), 10'd10, 10'd80, 10'd70, 10'd45, 1'b0};
        tbl[4] = '{w8(0, 1, 2, 3, 4, 5, 6, 7), 10'd0, 10'd7, 10'd7, 10'd3, 1'b1};
        tbl[5] = '{w8(1022, 1, 500, 500, 500, 500, 500, 500), 10'd1, 10'd1022, 10'd1021,
                   10'd511, 1'b0};

        bus.en_i      = 1'b0;
        bus.din_vld_i = 1'b0;
        bus.din_i     = '0;
        #2 rst_ni = 1'b0;
        #1 chk_reset_vals("por");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Back-to-back windows: the sample in each latch cycle opens the next window.
        start_meas();
        for (int k = 0; k < 6; k++) begin
            send_window(tbl[k].smp, early);
            chk($sformatf("win%0d early meas_vld", k), 32'(early), 0);
            chk($sformatf("win%0d meas_vld", k), 32'(bus.meas_vld_o), 1);
            chk($sformatf("win%0d min", k), 32'(bus.min_o), 32'(tbl[k].mn));
            chk($sformatf("win%0d max", k), 32'(bus.max_o), 32'(tbl[k].mx));
            chk($sformatf("win%0d vpp", k), 32'(bus.vpp_o), 32'(tbl[k].vpp));
            chk($sformatf("win%0d mid", k), 32'(bus.mid_o), 32'(tbl[k].mid));
            chk($sformatf("win%0d overrange", k), 32'(bus.overrange_o), 32'(tbl[k].ovr));
        end
        bus.din_vld_i = 1'b0;
        tick();

        // Partial window abandoned by en=0, then a fresh window.
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.din_vld_i = 1'b1;
            bus.din_i     = 10'd5;
            tick();
            if (bus.meas_vld_o) seen = 1'b1;
        end
        bus.en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.meas_vld_o) seen = 1'b1;
        end
        chk("partial no meas_vld", 32'(seen), 0);
        chk("hold min", 32'(bus.min_o), 1);
        chk("hold max", 32'(bus.max_o), 1022);
        chk("hold vpp", 32'(bus.vpp_o), 1021);
        chk("hold mid", 32'(bus.mid_o), 511);
        bus.en_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.din_vld_i = 1'b1;
            bus.din_i     = 10'(50 + i);
            tick();
            if (bus.meas_vld_o) seen = 1'b1;
        end
        chk("refill no early meas_vld", 32'(seen), 0);
        bus.din_i = 10'd57;
        tick();
        chk("refill meas_vld", 32'(bus.meas_vld_o), 1);
        chk("refill min", 32'(bus.min_o), 50);
        chk("refill max", 32'(bus.max_o), 57);
        chk("refill vpp", 32'(bus.vpp_o), 7);
        chk("refill mid", 32'(bus.mid_o), 53);

        // Noise inside the hysteresis band around 512 never counts.
        start_meas();
        pulses = 0;
        for (int c = 0; c < 320; c++) begin
            bus.din_vld_i = 1'b1;
            bus.din_i     = 10'(509 + (c % 7));
            tick();
            if (bus.fre_vld_o) begin
                chk($sformatf("noise fre gate%0d", pulses), bus.fre_o, 0);
                pulses++;
            end
        end
        chk("noise mid", 32'(bus.mid_o), 512);
        chk("noise gate count", 32'(pulses), 3);

        // 200/800 square wave, period 10: ten rising crossings per full gate.
        start_meas();
        pulses = 0;
        last   = -1;
        for (int c = 0; c < 450; c++) begin
            bus.din_vld_i = 1'b1;
            bus.din_i     = ((c % 10) < 5) ? 10'd200 : 10'd800;
            tick();
            if (bus.fre_vld_o) begin
                if (last >= 0) begin
                    chk($sformatf("sq gate interval%0d", pulses), 32'(c - last), 100);
                    chk($sformatf("sq fre gate%0d", pulses), bus.fre_o, 10);
                end
                pulses++;
                last = c;
            end
        end
        chk("sq gate count", 32'(pulses), 4);
        chk("sq mid", 32'(bus.mid_o), 500);

        // Asynchronous reset in the middle of a window, away from any clock edge.
        for (int i = 0; i < 3; i++) begin
            bus.din_i = 10'd300;
            tick();
        end
        #2 rst_ni = 1'b0;
        #1 chk_reset_vals("async rst");
        bus.din_vld_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wave_meas_param.md
Name: wave_meas_param

Overview:
- Parametrised waveform measurement block for the oscilloscope front end.
- Per sample window: min, max, peak-to-peak and midpoint, all registered.
- Per timebase gate: frequency, counted as hysteresis-qualified rising crossings of the previous window's midpoint.
- Outputs feed the on-screen readout and the vertical-scale/voltage lookup logic downstream.

Parameters:
DATA_W, 10, sample width (unsigned)
CNT_W, 32, frequency counter width
WIN_LEN, 1000000, accepted samples per min/max window (>=2)
GATE_LEN, 50000000, clocks per frequency gate (1 s at 50 MHz gives fre in Hz)
HYST, 4, hysteresis half-band in LSBs

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  measurement enable
din_vld  in  1  sample strobe
din  in  DATA_W  sample
min  out  DATA_W  window minimum
max  out  DATA_W  window maximum
vpp  out  DATA_W  max-min
mid  out  DATA_W  (min+max)>>1, crossing threshold
fre  out  CNT_W  rising crossings in last gate
meas_vld  out  1  1-cycle pulse, min/max/vpp/mid updated
fre_vld  out  1  1-cycle pulse, fre updated
overrange  out  1  last window contained a sample equal to 0 or 2^DATA_W-1

Behaviour:
- Interface: one clock clk; reset rst is asynchronous, active-low. All state clears immediately on rst=0.
- Reset values: min=0, max=0, vpp=0, mid=2^(DATA_W-1), fre=0, meas_vld=0, fre_vld=0, overrange=0.
- FSM states:
  - IDLE: en=0; window/gate counters cleared; outputs hold their last values; no vld pulses.
  - FIRST: waiting for the first sample of a window. On din_vld: run_min=run_max=din, win_cnt=1, run_ovr=clip(din); go to ACQ.
  - ACQ: on din_vld, update run_min and run_max independently (one sample may update both). win_cnt++.
- Transitions:
  - IDLE->FIRST on en=1.
  - Any state->IDLE on en=0. A partial window is discarded; no meas_vld.
- Window end (din_vld with win_cnt==WIN_LEN-1):
  - The next cycle latches min/max/vpp/mid/overrange and pulses meas_vld. The latched values include the final sample.
  - FSM returns to FIRST. A din_vld in that latch cycle is the first sample of the new window (no sample lost).
- Arithmetic: mid uses a DATA_W+1-bit sum, then right shift. vpp is never negative.
- Crossing detector (sub-module):
  - thr_hi = mid+HYST, saturated at full scale; thr_lo = mid-HYST, saturated at 0.
  - armed clears on reset or entering IDLE.
  - din<=thr_lo sets armed. din>=thr_hi with armed=1 emits xing and clears armed.
  - Only din_vld samples are evaluated.
  - mid changing mid-gate takes effect the cycle after meas_vld.
- Frequency gate (ACQ or FIRST only):
  - gate_cnt counts clocks 0..GATE_LEN-1.
  - At GATE_LEN-1: fre <= xing_cnt (+1 if xing that cycle, saturated), pulse fre_vld, xing_cnt <= 0.
  - xing_cnt saturates at all-ones; it never wraps.
- Latency:
  - meas_vld: 1 cycle after the last window sample.
  - xing: 1 cycle after the qualifying sample.
- Simultaneous meas_vld and fre_vld are legal and independent.

Decomposition:
- Package wave_meas_pkg holds:
  - FSM state encoding (IDLE/FIRST/ACQ).
  - Saturating add/sub helper functions.
  - The HALF_SCALE constant function of DATA_W.
- Sub-module schmitt_xing_det:
  - Inputs: clk, rst, clr, din_vld, din, mid, HYST.
  - Output: 1-cycle xing pulse.

Test Plan (DATA_W=10, WIN_LEN=8, GATE_LEN=100, HYST=4):
1. en=1, continuous din_vld, din 100..107 -> meas_vld one cycle after 107; min=100, max=107, vpp=7, mid=103, overrange=0.
2. Window 500,400,300,200,600,100,350,450 -> min=100, max=600, vpp=500, mid=350. Covers a sample updating max after min decreased.
3. Square wave 200/800, period 10 clocks, continuous samples -> from the second gate onward, fre=10 and fre_vld every 100 clocks.
4. din=512±3 noise with mid=512 -> fre=0 every gate.
5. Window containing 1023 -> overrange=1. Next clean window -> overrange=0.
6. en deasserted after 5 samples, then reasserted -> no meas_vld from the partial window; outputs hold. Next meas_vld only after 8 fresh samples.
7. rst pulsed low mid-window -> all outputs take their reset values immediately, without a clock edge.
